fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Parametrised program-counter sequencer for the single-cycle core's instruction-fetch stage. It generalises the existing start/halt/branch fetch with configurable PC width and four branch modes: absolute, PC-relative, call and return. Call and return use a return-address stack of configurable depth. It also adds stall support and explicit run/done status. `PC` drives the instruction ROM read address directly.

## Interface
- `PC_size`, default 16: PC and address width in bits.
- `RAS_DEPTH`, default 4: return-address stack entries; must be ≥ 2.
- `CLK` input, 1 bit: system clock, rising-edge.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `Start` input, 1 bit: load `StartAddress` and begin running.
- `StartAddress` input, `PC_size` bits: first instruction address.
- `Halt` input, 1 bit: stop fetching and freeze `PC`.
- `Stall` input, 1 bit: hold `PC` for this cycle.
- `Branch` input, 1 bit: take a control transfer this cycle.
- `BranchMode` input, 2 bits: 0 = ABS, 1 = REL, 2 = CALL, 3 = RET.
- `BranchTarget` input, `PC_size` bits: absolute target (ABS, CALL) or two's-complement offset (REL); ignored for RET.
- `PC` output, `PC_size` bits: current fetch address.
- `Running` output, 1 bit: state is RUN.
- `Done` output, 1 bit: state is HALTED.
- `RasOverflow` output, 1 bit: sticky; a CALL was made with the stack full.
- `RasUnderflow` output, 1 bit: sticky; a RET was made with the stack empty.
- Clock and reset: one clock; `Reset` is synchronous and active-high.

## Operation
- States:
  - IDLE (reset state): `PC` holds; only `Start` is acted on.
  - RUN: fetching.
  - HALTED: `PC` frozen at the value it held when halted; `Done` = 1.
- Reset values: state IDLE, `PC` = 0, `Running` = 0, `Done` = 0, stack empty (count 0), both flags 0.
- IDLE -> RUN on `Start`: `PC` <= `StartAddress`.
- RUN per-cycle priority, highest first:
  - `Start`: `PC` <= `StartAddress`; stack cleared; flags cleared.
  - `Halt`: go to HALTED; `PC` holds.
  - `Stall`: `PC` holds; the stack is untouched even if `Branch` is asserted.
  - `Branch`:
    - ABS: `PC` <= `BranchTarget`.
    - REL: `PC` <= `PC` + `BranchTarget`, both taken as `PC_size`-bit values, result modulo 2^`PC_size`.
    - CALL: push `PC`+1 (wrapped), then `PC` <= `BranchTarget`. If the stack is full, the oldest entry is overwritten (circular), the count stays at `RAS_DEPTH`, and `RasOverflow` is set.
    - RET: if the stack is not empty, pop and `PC` <= the popped value. If it is empty, `PC` <= `PC`+1 and `RasUnderflow` is set.
  - Otherwise: `PC` <= `PC`+1.
- All `PC` arithmetic is `PC_size` bits wide. `PC` = all-ones increments to 0.
- HALTED -> RUN only on `Start`, with the same actions as a RUN restart (load `StartAddress`, clear stack and flags). `Halt`, `Stall` and `Branch` are ignored while HALTED.
- `Reset` overrides everything, including mid-call and mid-halt, and returns to the IDLE reset values.

## Timing
- Fully synchronous. All inputs are sampled on the rising edge of `CLK`, and `PC` takes its new value after that edge: one-cycle latency from an input to `PC`.
- `Running`, `Done` and the flags are decoded from registered state only, with no combinational path from inputs to outputs.
- A CALL in cycle n followed by a RET in cycle n+1 returns to the CALL's `PC`+1. The push and the pop use the same stack pointer register, so no bypass is needed.
- A simultaneous push and overflow, or a pop and underflow, updates its flag in the same cycle as the `PC` update.

## Structure
- Package `fetch_pkg` holds:
  - the `branch_mode_t` enum (ABS, REL, CALL, RET);
  - the `fetch_state_t` enum (IDLE, RUN, HALTED).
- Sub-module `return_stack`, parametrised by `PC_size` and `RAS_DEPTH`:
  - inputs: push, pop, clear, data in;
  - outputs: top, empty, full;
  - the circular overwrite on full is implemented here.
- The top level holds the state machine, the next-PC multiplexer and the sticky flags.

## Test plan
- Reset, then `Start` with `StartAddress` = 1, then 3 idle cycles: `PC` = 1, 2, 3, 4; `Running` = 1.
- `Halt` at `PC` = 4 for one cycle, then 5 cycles of `Branch`/ABS to 20: `PC` stays 4 and `Done` = 1. Then `Start` with `StartAddress` = 8: `PC` = 8 and `Done` = 0.
- REL with offset 16'hFFFE at `PC` = 10 gives `PC` = 8. Increment from 16'hFFFF gives `PC` = 0.
- CALL to 20 at `PC` = 5, CALL to 40 at `PC` = 21, then RET, RET: `PC` sequence 20, 40, 22, 6. Neither flag is set.
- 5 CALLs with `RAS_DEPTH` = 4, then 5 RETs: the first 4 RETs return the last 4 return addresses in LIFO order. The 5th RET gives `PC`+1 with `RasUnderflow` = 1. `RasOverflow` = 1.
- `Stall` together with `Branch`/CALL, then `Reset` asserted mid-run: `PC` and stack unchanged during the stall. After `Reset`, `PC` = 0, IDLE, flags 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction-fetch PC sequencer.
//   branch_mode_t : encoding of the BranchMode input (ABS, REL, CALL, RET)
//   fetch_state_t : sequencer state (IDLE, RUN, HALTED)
package fetch_pkg;

    typedef enum logic [1:0] {
        BR_ABS  = 2'd0,
        BR_REL  = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } branch_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// return_stack: circular return-address stack for CALL/RET.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   push, pop         : push data_in / pop top (push wins if both are high)
//   clear             : empty the stack
//   data_in           : return address to push
//   top               : most recently pushed live entry
//   empty, full       : occupancy status
// When full, a push overwrites the oldest entry and the count saturates.
module return_stack #(
    parameter int PC_size   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [PC_size-1:0] data_in,
    output logic [PC_size-1:0] top,
    output logic               empty,
    output logic               full
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [PC_size-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]   ptr;      // next write slot
    logic [PTR_W-1:0]   ptr_inc;
    logic [PTR_W-1:0]   ptr_dec;
    logic [CNT_W-1:0]   count;

    // Explicit wrap so non-power-of-two depths work.
    always_comb begin
        ptr_inc = (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        ptr_dec = (ptr == '0) ? LAST : ptr - PTR_W'(1);
    end

    assign top   = mem[ptr_dec];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // When full, ptr already points at the oldest entry, so a plain
    // push overwrites it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            mem[ptr] <= data_in;
            ptr      <= ptr_inc;
            if (!full) count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer for the instruction-fetch stage.
// Ports:
//   CLK, Reset          : clock and synchronous active-high reset
//   Start, StartAddress : (re)start fetching at StartAddress
//   Halt                : stop and freeze PC
//   Stall               : hold PC this cycle
//   Branch, BranchMode, BranchTarget : control transfer (ABS/REL/CALL/RET)
//   PC                  : fetch address (drives instruction ROM)
//   Running, Done       : state is RUN / HALTED
//   RasOverflow, RasUnderflow : sticky return-stack error flags
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_size   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Start,
    input  logic [PC_size-1:0] StartAddress,
    input  logic               Halt,
    input  logic               Stall,
    input  logic               Branch,
    input  logic [1:0]         BranchMode,
    input  logic [PC_size-1:0] BranchTarget,
    output logic [PC_size-1:0] PC,
    output logic               Running,
    output logic               Done,
    output logic               RasOverflow,
    output logic               RasUnderflow
);
    fetch_state_t       state;
    branch_mode_t       mode;
    logic [PC_size-1:0] pc_inc;
    logic               take;
    logic               do_push;
    logic               do_pop;
    logic [PC_size-1:0] ras_top;
    logic               ras_empty;
    logic               ras_full;

    // A branch is only taken in RUN when nothing of higher priority fires.
    always_comb begin
        mode    = branch_mode_t'(BranchMode);
        pc_inc  = PC + PC_size'(1);
        take    = (state == ST_RUN) && !Start && !Halt && !Stall && Branch;
        do_push = take && (mode == BR_CALL);
        do_pop  = take && (mode == BR_RET) && !ras_empty;
    end

    return_stack #(
        .PC_size   (PC_size),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (CLK),
        .reset   (Reset),
        .push    (do_push),
        .pop     (do_pop),
        .clear   (Start),   // stack is already empty in IDLE, so clearing there is harmless
        .data_in (pc_inc),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state        <= ST_IDLE;
            PC           <= '0;
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        PC    <= StartAddress;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (Start) begin
                        PC           <= StartAddress;
                        RasOverflow  <= 1'b0;
                        RasUnderflow <= 1'b0;
                    end else if (Halt) begin
                        state <= ST_HALTED;
                    end else if (Stall) begin
                        PC <= PC;
                    end else if (Branch) begin
                        case (mode)
                            BR_ABS:  PC <= BranchTarget;
                            BR_REL:  PC <= PC + BranchTarget;
                            BR_CALL: begin
                                PC <= BranchTarget;
                                if (ras_full) RasOverflow <= 1'b1;
                            end
                            BR_RET: begin
                                if (!ras_empty) begin
                                    PC <= ras_top;
                                end else begin
                                    PC           <= pc_inc;
                                    RasUnderflow <= 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        PC <= pc_inc;
                    end
                end
                ST_HALTED: begin
                    if (Start) begin
                        PC           <= StartAddress;
                        RasOverflow  <= 1'b0;
                        RasUnderflow <= 1'b0;
                        state        <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Running = (state == ST_RUN);
    assign Done    = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each stimulus cycle pushes the
// hand-computed post-edge outputs; a monitor pops and compares after each edge.
module tb_fetch_sequencer;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         Reset, Start, Halt, Stall, Branch;
    logic [W-1:0] StartAddress, BranchTarget;
    logic [1:0]   BranchMode;
    logic [W-1:0] PC;
    logic         Running, Done, RasOverflow, RasUnderflow;

    fetch_sequencer #(.PC_size(W), .RAS_DEPTH(4)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Start        (Start),
        .StartAddress (StartAddress),
        .Halt         (Halt),
        .Stall        (Stall),
        .Branch       (Branch),
        .BranchMode   (BranchMode),
        .BranchTarget (BranchTarget),
        .PC           (PC),
        .Running      (Running),
        .Done         (Done),
        .RasOverflow  (RasOverflow),
        .RasUnderflow (RasUnderflow)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] step;
        logic [W-1:0] pc;
        logic run;
        logic done;
        logic ovf;
        logic unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   step_no = 0;

    // Monitor: one expected entry per clock edge while the queue has entries.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (PC === e.pc && Running === e.run && Done === e.done &&
                RasOverflow === e.ovf && RasUnderflow === e.unf) begin
                passed++;
            end else begin
                $display("FAIL step%0d: got pc=%h run=%b done=%b ovf=%b unf=%b, want pc=%h run=%b done=%b ovf=%b unf=%b",
                         e.step, PC, Running, Done, RasOverflow, RasUnderflow,
                         e.pc, e.run, e.done, e.ovf, e.unf);
            end
        end
    end

    // ctl = {Reset, Start, Halt, Stall, Branch}; mode 0=ABS 1=REL 2=CALL 3=RET
    task automatic cyc(input logic [4:0] ctl, input logic [W-1:0] sa,
                       input logic [1:0] md, input logic [W-1:0] bt,
                       input logic [W-1:0] epc, input logic erun, input logic edone,
                       input logic eovf, input logic eunf);
        exp_t e;
        {Reset, Start, Halt, Stall, Branch} = ctl;
        StartAddress = sa;
        BranchMode   = md;
        BranchTarget = bt;
        step_no++;
        e.step = 16'(step_no);
        e.pc   = epc;
        e.run  = erun;
        e.done = edone;
        e.ovf  = eovf;
        e.unf  = eunf;
        exp_q.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    localparam logic [4:0] NOP = 5'b00000, RST = 5'b10000, STA = 5'b01000,
                           HLT = 5'b00100, BR  = 5'b00001, STB = 5'b00011;

    initial begin
        {Reset, Start, Halt, Stall, Branch} = '0;
        StartAddress = '0; BranchMode = '0; BranchTarget = '0;
        #2;
        // reset, then IDLE ignores branch
        cyc(RST, 0, 0, 0,      16'd0, 0, 0, 0, 0);
        cyc(BR,  0, 0, 20,     16'd0, 0, 0, 0, 0);
        // start at 1, count up
        cyc(STA, 1, 0, 0,      16'd1, 1, 0, 0, 0);
        cyc(NOP, 0, 0, 0,      16'd2, 1, 0, 0, 0);
        cyc(NOP, 0, 0, 0,      16'd3, 1, 0, 0, 0);
        cyc(NOP, 0, 0, 0,      16'd4, 1, 0, 0, 0);
        // halt, then branches ignored
        cyc(HLT, 0, 0, 0,      16'd4, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(BR, 0, 0, 20,  16'd4, 0, 1, 0, 0);
        cyc(STA, 8, 0, 0,      16'd8, 1, 0, 0, 0);
        // REL backwards by 2 from 10
        cyc(NOP, 0, 0, 0,      16'd9, 1, 0, 0, 0);
        cyc(NOP, 0, 0, 0,      16'd10, 1, 0, 0, 0);
        cyc(BR,  0, 1, 16'hFFFE, 16'd8, 1, 0, 0, 0);
        // wrap at all-ones
        cyc(BR,  0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 0, 0);
        cyc(NOP, 0, 0, 0,      16'd0, 1, 0, 0, 0);
        // nested call/return, back-to-back CALL then RET
        cyc(BR,  0, 0, 5,      16'd5, 1, 0, 0, 0);
        cyc(BR,  0, 2, 20,     16'd20, 1, 0, 0, 0);
        cyc(NOP, 0, 0, 0,      16'd21, 1, 0, 0, 0);
        cyc(BR,  0, 2, 40,     16'd40, 1, 0, 0, 0);
        cyc(BR,  0, 3, 0,      16'd22, 1, 0, 0, 0);
        cyc(BR,  0, 3, 0,      16'd6, 1, 0, 0, 0);
        // overflow: 5 calls into a 4-deep stack
        cyc(STA, 100, 0, 0,    16'd100, 1, 0, 0, 0);
        cyc(BR,  0, 2, 200,    16'd200, 1, 0, 0, 0);
        cyc(BR,  0, 2, 300,    16'd300, 1, 0, 0, 0);
        cyc(BR,  0, 2, 400,    16'd400, 1, 0, 0, 0);
        cyc(BR,  0, 2, 500,    16'd500, 1, 0, 0, 0);
        cyc(BR,  0, 2, 600,    16'd600, 1, 0, 1, 0);
        cyc(BR,  0, 3, 0,      16'd501, 1, 0, 1, 0);
        cyc(BR,  0, 3, 0,      16'd401, 1, 0, 1, 0);
        cyc(BR,  0, 3, 0,      16'd301, 1, 0, 1, 0);
        cyc(BR,  0, 3, 0,      16'd201, 1, 0, 1, 0);
        cyc(BR,  0, 3, 0,      16'd202, 1, 0, 1, 1);
        // stall with CALL: no PC change, no push (next RET still underflows)
        cyc(STB, 0, 2, 700,    16'd202, 1, 0, 1, 1);
        cyc(BR,  0, 3, 0,      16'd203, 1, 0, 1, 1);
        // restart from RUN clears flags
        cyc(STA, 50, 0, 0,     16'd50, 1, 0, 0, 0);
        cyc(BR,  0, 2, 70,     16'd70, 1, 0, 0, 0);
        // reset mid-call
        cyc(RST, 0, 0, 0,      16'd0, 0, 0, 0, 0);
        cyc(NOP, 0, 0, 0,      16'd0, 0, 0, 0, 0);
        // stack was cleared by reset: RET underflows
        cyc(STA, 3, 0, 0,      16'd3, 1, 0, 0, 0);
        cyc(BR,  0, 3, 0,      16'd4, 1, 0, 0, 1);
        cyc(NOP, 0, 0, 0,      16'd5, 1, 0, 0, 1);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        #3;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
